// File: rtl/mul4_rr_scheduler_pkg.sv
// Shared types and widths for the round-robin 4x4 multiplier scheduler.
package mul_sched_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int OPW  = 4;
   localparam int PW   = 8;
   localparam int CNTW = 16;
endpackage

// File: rtl/mul4_rr_scheduler_if.sv
// Requester-side handshake bundle; slave is the scheduler, master is the client side.
interface mul4_rr_scheduler_if #(parameter int NREQ = 2);
   import mul_sched_pkg::*;

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [OPW*NREQ-1:0] req_x;
   logic [OPW*NREQ-1:0] req_y;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [PW-1:0]       rsp_s;
   logic                busy;
   logic [CNTW-1:0]     ops_done;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_s, busy, ops_done
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_s, busy, ops_done
   );
endinterface

// File: rtl/mul4_rr_scheduler_core.sv
// Combinational 4x4 unsigned array multiplier: one ripple row of full adders per Y bit.
module mul4_core
   import mul_sched_pkg::*;
(
   input  logic [OPW-1:0] X,
   input  logic [OPW-1:0] Y,
   output logic [PW-1:0]  s
);

   function automatic logic [1:0] f_fa(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   always_comb begin
      logic [3:0] w_up;
      logic [3:0] w_t;
      logic       w_c;
      logic [1:0] w_fa;
      s    = '0;
      w_t  = '0;
      w_c  = 1'b0;
      w_fa = '0;
      s[0] = X[0] & Y[0];
      // w_up carries the running partial sum aligned to the next row's weight
      w_up = {1'b0, X[3:1] & {3{Y[0]}}};
      for (int i = 1; i < 4; i++) begin
         w_c = 1'b0;
         for (int j = 0; j < 4; j++) begin
            w_fa   = f_fa(w_up[j], X[j] & Y[i], w_c);
            w_t[j] = w_fa[0];
            w_c    = w_fa[1];
         end
         s[i] = w_t[0];
         w_up = {w_c, w_t[3:1]};
      end
      s[7:4] = w_up;
   end

endmodule

// File: rtl/mul4_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters.
module mul4_rr_scheduler
   import mul_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                clk,
   input  logic                rst,
   mul4_rr_scheduler_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_MUL  = MUL;
   localparam logic [1:0] ST_RESP = RESP;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   logic [1:0]      r_state;
   logic [1:0]      r_last;
   logic [1:0]      r_id;
   logic [OPW-1:0]  r_x;
   logic [OPW-1:0]  r_y;
   logic [PW-1:0]   r_res;
   logic [CNTW-1:0] r_ops_done;
   logic            r_busy;

   logic [2:0]      w_pick;
   logic            w_found;
   logic [1:0]      w_id;
   logic [NREQ-1:0] w_grant;
   logic [NREQ-1:0] w_rsp_sel;
   logic            w_rsp_hs;
   logic [PW-1:0]   w_prod;

   // Returns {found, index}: first valid requester after 'last', wrapping mod NREQ.
   function automatic logic [2:0] f_pick(input logic [NREQ-1:0] v, input logic [1:0] last);
      logic [3:0] v4;
      logic [1:0] idx;
      logic [2:0] r;
      v4 = 4'(v);
      r  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = 2'((int'(last) + k) % NREQ);
         if (!r[2] && v4[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign w_pick    = f_pick(bus.req_valid, r_last);
   assign w_found   = w_pick[2];
   assign w_id      = w_pick[1:0];
   assign w_grant   = (r_state == ST_IDLE && w_found) ? (ONE << w_id) : '0;
   assign w_rsp_sel = (r_state == ST_RESP) ? (ONE << r_id) : '0;
   assign w_rsp_hs  = |(bus.rsp_ready & w_rsp_sel);

   mul4_core u_core (
      .X (r_x),
      .Y (r_y),
      .s (w_prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last     <= 2'(NREQ - 1);
         r_id       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_res      <= '0;
         r_ops_done <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_x     <= bus.req_x[{w_id, 2'b00} +: OPW];
                  r_y     <= bus.req_y[{w_id, 2'b00} +: OPW];
                  r_id    <= w_id;
                  r_state <= ST_MUL;
                  r_busy  <= 1'b1;
               end
            end
            ST_MUL: begin
               r_res   <= w_prod;
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_hs) begin
                  r_last     <= r_id;
                  r_ops_done <= r_ops_done + 1'b1;
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = w_rsp_sel;
   assign bus.rsp_s     = r_res;
   assign bus.busy      = r_busy;
   assign bus.ops_done  = r_ops_done;

endmodule

// File: tb/tb_mul4_rr_scheduler.sv
// Scoreboard bench for mul4_rr_scheduler with two requesters.
module tb_mul4_rr_scheduler;
   localparam int NREQ = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;
   logic [9:0] exp_q[$];

   mul4_rr_scheduler_if #(.NREQ(NREQ)) ifc();

   mul4_rr_scheduler #(.NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      ifc.req_valid = '0;
      ifc.req_x     = '0;
      ifc.req_y     = '0;
      ifc.rsp_ready = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
      n_chk++;
      if (ifc.rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", ifc.rsp_valid); end
      n_chk++;
      if (ifc.rsp_s !== 8'd0) begin n_err++; $display("FAIL reset_rsp_s got=%0d exp=0", ifc.rsp_s); end
      n_chk++;
      if (ifc.ops_done !== 16'd0) begin n_err++; $display("FAIL reset_ops_done got=%0d exp=0", ifc.ops_done); end
      n_chk++;
      if (ifc.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b exp=00", ifc.req_ready); end
      rst = 1'b0;
      @(negedge clk);
      ifc.req_valid = 2'b11;
      #1;
      n_chk++;
      if (ifc.req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant got=%b exp=01", ifc.req_ready); end
      ifc.req_valid = 2'b00;
   endtask

   task automatic test_single();
      int xs[5] = '{2, 10, 6, 11, 15};
      int ys[5] = '{2, 2, 10, 3, 3};
      logic [9:0] e;
      apply_reset();
      ifc.rsp_ready = 2'b01;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         ifc.req_valid      = 2'b01;
         ifc.req_x[3:0]     = 4'(xs[k]);
         ifc.req_y[3:0]     = 4'(ys[k]);
         exp_q.push_back({2'd0, 8'(xs[k] * ys[k])});
         #1;
         n_chk++;
         if (ifc.req_ready !== 2'b01) begin n_err++; $display("FAIL single_grant op=%0d got=%b exp=01", k, ifc.req_ready); end
         @(negedge clk);
         ifc.req_valid = 2'b00;
         n_chk++;
         if (ifc.rsp_valid !== 2'b00 || ifc.busy !== 1'b1 || ifc.req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL single_mul op=%0d got rsp_valid=%b busy=%b req_ready=%b exp 00/1/00",
                     k, ifc.rsp_valid, ifc.busy, ifc.req_ready);
         end
         @(negedge clk);
         e = exp_q.pop_front();
         n_chk++;
         if (ifc.rsp_valid !== (2'b01 << e[9:8]) || ifc.rsp_s !== e[7:0]) begin
            n_err++;
            $display("FAIL single_rsp op=%0d got valid=%b s=%0d exp valid=%b s=%0d",
                     k, ifc.rsp_valid, ifc.rsp_s, 2'b01 << e[9:8], e[7:0]);
         end
      end
      @(negedge clk);
      n_chk++;
      if (ifc.ops_done !== 16'd5 || ifc.busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_ops_done got=%0d busy=%b exp=5 busy=0", ifc.ops_done, ifc.busy);
      end
   endtask

   task automatic test_simultaneous();
      logic [9:0] e;
      logic [1:0] g;
      int cnt;
      apply_reset();
      ifc.rsp_ready = 2'b11;
      ifc.req_x     = {4'd7, 4'd15};
      ifc.req_y     = {4'd9, 4'd15};
      @(negedge clk);
      ifc.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         cnt = 0;
         while (ifc.req_ready === 2'b00 && cnt < 10) begin @(negedge clk); #1; cnt++; end
         exp_q.push_back({(k % 2 == 0) ? 2'd0 : 2'd1, (k % 2 == 0) ? 8'd225 : 8'd63});
         n_chk++;
         if (ifc.req_ready !== g) begin n_err++; $display("FAIL simul_grant op=%0d got=%b exp=%b", k, ifc.req_ready, g); end
         @(negedge clk);
         cnt = 0;
         while (ifc.rsp_valid === 2'b00 && cnt < 10) begin @(negedge clk); cnt++; end
         e = exp_q.pop_front();
         n_chk++;
         if (ifc.rsp_valid !== (2'b01 << e[9:8]) || ifc.rsp_s !== e[7:0]) begin
            n_err++;
            $display("FAIL simul_rsp op=%0d got valid=%b s=%0d exp valid=%b s=%0d",
                     k, ifc.rsp_valid, ifc.rsp_s, 2'b01 << e[9:8], e[7:0]);
         end
         @(negedge clk);
      end
      ifc.req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      logic [9:0] e;
      apply_reset();
      @(negedge clk);
      ifc.req_valid  = 2'b01;
      ifc.req_x[3:0] = 4'd3;
      ifc.req_y[3:0] = 4'd5;
      exp_q.push_back({2'd0, 8'd15});
      @(negedge clk);
      ifc.req_valid = 2'b00;
      @(negedge clk);
      ifc.req_valid = 2'b11;
      ifc.rsp_ready = 2'b10;
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++;
         if (ifc.rsp_valid !== 2'b01 || ifc.rsp_s !== e[7:0] || ifc.req_ready !== 2'b00 || ifc.ops_done !== 16'd0) begin
            n_err++;
            $display("FAIL bp_hold cyc=%0d got valid=%b s=%0d req_ready=%b ops=%0d exp 01/%0d/00/0",
                     i, ifc.rsp_valid, ifc.rsp_s, ifc.req_ready, ifc.ops_done, e[7:0]);
         end
         @(negedge clk);
      end
      ifc.req_valid = 2'b00;
      ifc.rsp_ready = 2'b01;
      @(negedge clk);
      n_chk++;
      if (ifc.rsp_valid !== 2'b00 || ifc.ops_done !== 16'd1) begin
         n_err++;
         $display("FAIL bp_complete got valid=%b ops=%0d exp 00/1", ifc.rsp_valid, ifc.ops_done);
      end
      @(negedge clk);
      n_chk++;
      if (ifc.ops_done !== 16'd1 || ifc.busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_count_once got ops=%0d busy=%b exp 1/0", ifc.ops_done, ifc.busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] e;
      apply_reset();
      ifc.rsp_ready = 2'b11;
      @(negedge clk);
      ifc.req_valid  = 2'b01;
      ifc.req_x[3:0] = 4'd3;
      ifc.req_y[3:0] = 4'd3;
      exp_q.push_back({2'd0, 8'd9});
      @(negedge clk);
      ifc.req_valid = 2'b00;
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (ifc.rsp_s !== e[7:0]) begin n_err++; $display("FAIL rmid_first got=%0d exp=%0d", ifc.rsp_s, e[7:0]); end
      @(negedge clk);
      ifc.req_valid  = 2'b10;
      ifc.req_x[7:4] = 4'd4;
      ifc.req_y[7:4] = 4'd4;
      #1;
      n_chk++;
      if (ifc.req_ready !== 2'b10) begin n_err++; $display("FAIL rmid_grant1 got=%b exp=10", ifc.req_ready); end
      @(negedge clk);
      ifc.req_valid = 2'b00;
      n_chk++;
      if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL rmid_in_mul busy got=%b exp=1", ifc.busy); end
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (ifc.busy !== 1'b0 || ifc.rsp_valid !== 2'b00 || ifc.rsp_s !== 8'd0 || ifc.ops_done !== 16'd0) begin
         n_err++;
         $display("FAIL rmid_async got busy=%b valid=%b s=%0d ops=%0d exp 0/00/0/0",
                  ifc.busy, ifc.rsp_valid, ifc.rsp_s, ifc.ops_done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if (ifc.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rmid_no_rsp cyc=%0d got=%b exp=00", i, ifc.rsp_valid); end
      end
      ifc.req_valid = 2'b11;
      #1;
      n_chk++;
      if (ifc.req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_regrant got=%b exp=01", ifc.req_ready); end
      ifc.req_valid = 2'b00;
   endtask

   task automatic test_sweep();
      logic [9:0] e;
      apply_reset();
      ifc.rsp_ready = 2'b10;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            @(negedge clk);
            ifc.req_valid  = 2'b10;
            ifc.req_x[7:4] = 4'(x);
            ifc.req_y[7:4] = 4'(y);
            exp_q.push_back({2'd1, 8'(x * y)});
            #1;
            n_chk++;
            if (ifc.req_ready !== 2'b10) begin n_err++; $display("FAIL sweep_grant x=%0d y=%0d got=%b exp=10", x, y, ifc.req_ready); end
            @(negedge clk);
            ifc.req_valid = 2'b00;
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (ifc.rsp_valid !== (2'b01 << e[9:8]) || ifc.rsp_s !== e[7:0]) begin
               n_err++;
               $display("FAIL sweep_rsp x=%0d y=%0d got valid=%b s=%0d exp valid=%b s=%0d",
                        x, y, ifc.rsp_valid, ifc.rsp_s, 2'b01 << e[9:8], e[7:0]);
            end
         end
      end
      @(negedge clk);
      n_chk++;
      if (ifc.ops_done !== 16'd256) begin n_err++; $display("FAIL sweep_ops_done got=%0d exp=256", ifc.ops_done); end
   endtask

   task automatic test_wrap();
      logic [9:0] e;
      @(negedge clk);
      force dut.r_ops_done = 16'hFFFF;
      @(negedge clk);
      release dut.r_ops_done;
      @(negedge clk);
      n_chk++;
      if (ifc.ops_done !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got=%h exp=ffff", ifc.ops_done); end
      ifc.rsp_ready  = 2'b01;
      ifc.req_valid  = 2'b01;
      ifc.req_x[3:0] = 4'd12;
      ifc.req_y[3:0] = 4'd13;
      exp_q.push_back({2'd0, 8'd156});
      @(negedge clk);
      ifc.req_valid = 2'b00;
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (ifc.rsp_valid !== 2'b01 || ifc.rsp_s !== e[7:0]) begin
         n_err++;
         $display("FAIL wrap_rsp got valid=%b s=%0d exp valid=01 s=%0d", ifc.rsp_valid, ifc.rsp_s, e[7:0]);
      end
      @(negedge clk);
      n_chk++;
      if (ifc.ops_done !== 16'h0000) begin n_err++; $display("FAIL wrap_ops_done got=%h exp=0000", ifc.ops_done); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mul4_rr_scheduler.md
# mul4_rr_scheduler

Shares one combinational 4x4 unsigned multiplier core among `NREQ` requesters using round-robin arbitration and per-requester valid/ready handshakes. The scheduler accepts one operation, registers its operands, then registers the 8-bit product. It returns the product to the requester that issued the operation. It sits between the multiplier datapath and the client blocks that currently drive the multiplier inputs directly.

## Interface
- `NREQ`, default 2: number of requesters, 2..4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: requester i has an operation pending.
- `req_ready`  out  NREQ: one-hot grant; handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_x`  in  4*NREQ: operand X, slice [4i+3:4i] belongs to requester i.
- `req_y`  in  4*NREQ: operand Y, same slicing as `req_x`.
- `rsp_valid`  out  NREQ: one-hot; the result for requester i is available.
- `rsp_ready`  in  NREQ: requester i accepts the result.
- `rsp_s`  out  8: product, shared by all requesters and qualified by `rsp_valid`.
- `busy`  out  1: high whenever the scheduler is not in IDLE.
- `ops_done`  out  16: count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, MUL, RESP.
- **IDLE:**
  - Arbiter picks the first i with `req_valid[i]`, searching from `last_grant+1` mod NREQ upward.
  - `req_ready[pick]=1` combinationally; all other `req_ready` bits are 0.
  - If no `req_valid` bit is set, `req_ready` is all 0.
  - On handshake: latch `x_q`, `y_q` and `id_q=pick`, then go to MUL.
- **MUL:** `res_q <= core(x_q, y_q)`, then go to RESP. `req_ready` is all 0.
- **RESP:**
  - `rsp_valid[id_q]=1` and `rsp_s=res_q`; all other `rsp_valid` bits are 0.
  - Hold until `rsp_ready[id_q]`.
  - On the handshake: `last_grant<=id_q`, `ops_done<=ops_done+1`, then go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- **Arithmetic:** unsigned, product = X*Y, range 0..225, zero-extended into 8 bits. No overflow is possible.
- **Reset values:**
  - state=IDLE, `last_grant=NREQ-1` (so requester 0 wins first).
  - `x_q`, `y_q`, `id_q`, `res_q` = 0.
  - `ops_done`=0.
  - Outputs: `req_ready`=0 except the combinational IDLE grant, `rsp_valid`=0, `rsp_s`=0, `busy`=0.
- **Fairness:** a requester that holds `req_valid` high is served within NREQ operations.
- **Withdrawal:** a requester may drop `req_valid` before its handshake. The pick is re-evaluated every cycle in IDLE.
- **Reset mid-operation:** any state returns to IDLE immediately and the in-flight operation is discarded with no response.
- **Stability:** `rsp_s` and `rsp_valid` stay stable in RESP until the response handshake completes.

## Timing
- Operand handshake at edge t.
- MUL occupies cycle t..t+1, and `res_q` is written at edge t+1.
- `rsp_valid` is high from after edge t+1 until the response handshake.
- Minimum occupancy is 3 cycles per operation: IDLE grant, MUL, RESP with `rsp_ready` already high.
- The next grant comes in the IDLE cycle after the RESP handshake. There is no overlap between operations.
- `busy` is a registered function of state: high in MUL and RESP.
- The combinational path `req_valid` -> `req_ready` exists only in IDLE. There is no `rsp_ready` -> `req_ready` path.

## Structure
- Package `mul_sched_pkg`:
  - `state_t` enum {IDLE, MUL, RESP}.
  - Constants `OPW=4`, `PW=8`, `CNTW=16`.
- Sub-module `mul4_core`: purely combinational 4x4 unsigned array multiplier built from full-adder rows, with ports X[3:0], Y[3:0] and s[7:0]. It is instantiated once.
- The arbiter's rotate-priority pick is a function inside the scheduler, not a separate module.

## Test plan
- **Single requester sequence:** requester 0 issues 2x2, 10x2, 6x10, 11x3, 15x3, with `rsp_ready` tied high. Required responses: 4, 20, 60, 33, 45, each with `rsp_valid` 2 cycles after its grant. `ops_done` must equal 5 at the end.
- **Simultaneous requests:** NREQ=2, both requesters hold `req_valid` continuously with 15x15 (req0) and 7x9 (req1). Grants must alternate 0,1,0,1. Responses must be 225 on requester 0 and 63 on requester 1.
- **Backpressure:** hold `rsp_ready[0]=0` for 5 cycles in RESP. `rsp_valid[0]` and `rsp_s` must stay stable, `req_ready` must stay 0, and the completion is counted only once.
- **Reset mid-operation:** assert `rst` in MUL. Outputs must return to reset values asynchronously, and no response is issued. After release, requester 0 is granted first.
- **Exhaustive sweep:** all 256 X,Y pairs through requester 1. Every `rsp_s` must equal X*Y, and `ops_done` must equal 256.
- **Counter wrap:** preload or run until `ops_done`=0xFFFF, then complete one more operation. `ops_done` must read 0.
